// File: rtl/dc_pwm_pkg.sv
// -----------------------------------------------------------------------------
// dc_pwm_pkg
// Shared types and constants for the DC motor PWM decoder.
//   dc_state_e : measurement FSM states (idle, high phase, low phase)
//   speed_e    : 2-bit speed codes reported alongside the duty count
//   PERIOD_DEF / TIMEOUT_DEF : default nominal period and edge timeout (clocks)
//   SPD1_MAX / SPD2_MAX      : duty thresholds matching the controller's
//                              0/8/9/10-of-10 duty set
//   speed_map()              : duty count -> speed code
// -----------------------------------------------------------------------------
package dc_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } dc_state_e;

    typedef enum logic [1:0] {
        SPD_STOP = 2'd0,
        SPD_LOW  = 2'd1,
        SPD_MID  = 2'd2,
        SPD_FULL = 2'd3
    } speed_e;

    localparam int unsigned PERIOD_DEF  = 32'd10;
    localparam int unsigned TIMEOUT_DEF = 32'd20;
    localparam int unsigned SPD1_MAX    = 32'd8;
    localparam int unsigned SPD2_MAX    = 32'd9;

    // Anything above SPD2_MAX (a full-period or steady-high duty) is full speed.
    function automatic speed_e speed_map(input int unsigned duty_val);
        speed_e code;
        if (duty_val == 32'd0) begin
            code = SPD_STOP;
        end else if (duty_val <= SPD1_MAX) begin
            code = SPD_LOW;
        end else if (duty_val <= SPD2_MAX) begin
            code = SPD_MID;
        end else begin
            code = SPD_FULL;
        end
        return code;
    endfunction

endpackage

// File: rtl/dc_pwm_decoder_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// CW-wide up counter that sticks at its all-ones value instead of wrapping.
//   clk  in  : clock, rising edge
//   rst  in  : synchronous active-high reset (count -> 0)
//   clr  in  : restart the count; with en also high the count restarts at 1,
//              so the cycle that starts a phase is counted as its first cycle
//   en   in  : count this cycle
//   cnt  out : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: restart, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            if (en) begin
                cnt_d = CNT_ONE;
            end else begin
                cnt_d = '0;
            end
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dc_pwm_decoder.sv
// -----------------------------------------------------------------------------
// dc_pwm_decoder
// Recovers duty, period, direction and speed code from a two-wire H-bridge
// PWM drive by timing the high and low phases of whichever line is active.
//   PERIOD    : nominal PWM period; reported as duty for a steady-high line
//   TIMEOUT   : cycles without an edge before a steady level is published
//   CW        : width of counters and measurement outputs
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset
//   pwm_in    in  : bit0 forward drive, bit1 reverse drive
//   duty      out : high cycles of the last measured period
//   period    out : rise-to-rise cycles; 0 for a steady-level (timeout) result
//   speed     out : speed code of the published duty
//   direction out : 1 forward, 0 reverse
//   valid     out : one-cycle pulse when the measurement outputs update
//   fault     out : both drive lines high (shoot-through)
// -----------------------------------------------------------------------------
module dc_pwm_decoder
    import dc_pwm_pkg::*;
#(
    parameter int unsigned PERIOD  = PERIOD_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pwm_in,
    output logic [CW-1:0] duty,
    output logic [CW-1:0] period,
    output logic [1:0]    speed,
    output logic          direction,
    output logic          valid,
    output logic          fault
);

    localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
    localparam logic [CW-1:0] TO_LAST_C = CW'(TIMEOUT - 32'd1);

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] x,
                                              input logic [CW-1:0] y);
        logic [CW:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum[CW]) begin
            return {CW{1'b1}};
        end else begin
            return sum[CW-1:0];
        end
    endfunction

    // Registered state
    logic [1:0]    pwm_q;
    logic          act_dly_q;    // active level of the previous cycle
    logic          dir_hold_q;
    dc_state_e     state_q;
    logic [CW-1:0] duty_q;
    logic [CW-1:0] period_q;
    logic [1:0]    speed_q;
    logic          direction_q;
    logic          valid_q;
    logic          fault_q;

    // Next-state values
    logic          act_dly_d;
    logic          dir_hold_d;
    dc_state_e     state_d;
    logic [CW-1:0] duty_d;
    logic [CW-1:0] period_d;
    logic [1:0]    speed_d;
    logic          direction_d;
    logic          valid_d;
    logic          fault_d;

    // Edge detection and counter controls
    logic          act;
    logic          rise;
    logic          fall;
    logic          shoot;
    logic          to_hit;
    logic          hi_clr, hi_en;
    logic          lo_clr, lo_en;
    logic          to_clr, to_en;
    logic [CW-1:0] hi_cnt;
    logic [CW-1:0] lo_cnt;
    logic [CW-1:0] to_cnt;
    logic          pub;
    logic [CW-1:0] pub_duty;
    logic [CW-1:0] pub_period;

    sat_counter #(.CW(CW)) u_hi_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hi_clr),
        .en  (hi_en),
        .cnt (hi_cnt)
    );

    sat_counter #(.CW(CW)) u_lo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (lo_clr),
        .en  (lo_en),
        .cnt (lo_cnt)
    );

    sat_counter #(.CW(CW)) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (to_clr),
        .en  (to_en),
        .cnt (to_cnt)
    );

    // Input sampling register; it keeps sampling through reset so that a line
    // already high when reset releases is not mistaken for a rise.
    always_ff @(posedge clk) begin
        pwm_q <= pwm_in;
    end

    // Level/edge decode. A 01->10 swap keeps act high, so it is not an edge.
    // An edge this cycle suppresses the timeout that would otherwise fire.
    always_comb begin
        act    = pwm_q[0] | pwm_q[1];
        rise   = act & ~act_dly_q;
        fall   = ~act & act_dly_q;
        shoot  = (pwm_q == 2'b11);
        to_hit = (to_cnt == TO_LAST_C) & ~rise & ~fall;
    end

    // Direction follows the most recent single active line.
    always_comb begin
        case (pwm_q)
            2'b01:   dir_hold_d = 1'b1;
            2'b10:   dir_hold_d = 1'b0;
            default: dir_hold_d = dir_hold_q;
        endcase
    end

    // Measurement FSM next state, counter controls and publish decision.
    // Priority: shoot-through, then timeout, then normal phase tracking.
    always_comb begin
        state_d    = state_q;
        hi_clr     = 1'b0;
        hi_en      = 1'b0;
        lo_clr     = 1'b0;
        lo_en      = 1'b0;
        to_clr     = rise | fall;
        to_en      = ~(rise | fall);
        pub        = 1'b0;
        pub_duty   = '0;
        pub_period = '0;
        if (shoot) begin
            // Abandon the partial period; nothing is published.
            state_d = ST_IDLE;
            hi_clr  = 1'b1;
            lo_clr  = 1'b1;
            to_clr  = 1'b1;
            to_en   = 1'b0;
        end else if (to_hit) begin
            pub        = 1'b1;
            pub_duty   = act ? PERIOD_C : '0;
            pub_period = '0;
            state_d    = ST_IDLE;
            hi_clr     = 1'b1;
            lo_clr     = 1'b1;
            to_clr     = 1'b1;
            to_en      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        hi_clr  = 1'b1;
                        hi_en   = 1'b1;
                        lo_clr  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (act) begin
                        hi_en = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        lo_clr  = 1'b1;
                        lo_en   = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        pub        = 1'b1;
                        pub_duty   = hi_cnt;
                        pub_period = sat_add(hi_cnt, lo_cnt);
                        state_d    = ST_HIGH;
                        hi_clr     = 1'b1;
                        hi_en      = 1'b1;
                        lo_clr     = 1'b1;
                    end else if (!act) begin
                        lo_en = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hi_clr  = 1'b1;
                    lo_clr  = 1'b1;
                end
            endcase
        end
    end

    // Output next values: measurements hold between publishes. Fault is
    // registered from the raw input so it is high exactly while pwm_q is 11.
    always_comb begin
        act_dly_d = act;
        valid_d   = pub;
        fault_d   = (pwm_in == 2'b11);
        if (pub) begin
            duty_d      = pub_duty;
            period_d    = pub_period;
            speed_d     = speed_map(32'(pub_duty));
            direction_d = dir_hold_q;
        end else begin
            duty_d      = duty_q;
            period_d    = period_q;
            speed_d     = speed_q;
            direction_d = direction_q;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            act_dly_q   <= 1'b1;
            dir_hold_q  <= 1'b0;
            duty_q      <= '0;
            period_q    <= '0;
            speed_q     <= 2'b00;
            direction_q <= 1'b0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_dly_q   <= act_dly_d;
            dir_hold_q  <= dir_hold_d;
            duty_q      <= duty_d;
            period_q    <= period_d;
            speed_q     <= speed_d;
            direction_q <= direction_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
        end
    end

    assign duty      = duty_q;
    assign period    = period_q;
    assign speed     = speed_q;
    assign direction = direction_q;
    assign valid     = valid_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_dc_pwm_decoder.sv
// -----------------------------------------------------------------------------
// tb_dc_pwm_decoder
// Directed bench for dc_pwm_decoder. Each expected publication (fields plus
// the sample cycle on which valid must appear) is queued when the stimulus
// that causes it is written; every valid pulse pops and compares one entry.
// Cycle n is the sample taken 1 time unit after the n-th rising clock edge.
// -----------------------------------------------------------------------------
module tb_dc_pwm_decoder;

    localparam int CW = 8;

    typedef struct {
        logic [7:0] duty;
        logic [7:0] period;
        logic [1:0] speed;
        logic       dir;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    pwm_in;
    logic [CW-1:0] duty;
    logic [CW-1:0] period;
    logic [1:0]    speed;
    logic          direction;
    logic          valid;
    logic          fault;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;
    int   cyc;

    dc_pwm_decoder #(.PERIOD(10), .TIMEOUT(20), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .speed     (speed),
        .direction (direction),
        .valid     (valid),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] p, input logic [1:0] s,
                        input logic dr, input int c);
        exp_t e;
        e.duty   = d;
        e.period = p;
        e.speed  = s;
        e.dir    = dr;
        e.cyc    = c;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of input, sample after the edge, score any valid pulse.
    task automatic step(input logic [1:0] v);
        exp_t e;
        pwm_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            check("valid_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
                check("pub_duty_period_speed_dir",
                      {13'd0, duty, period, speed, direction},
                      {13'd0, e.duty, e.period, e.speed, e.dir});
            end
        end
    endtask

    task automatic run(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            step(v);
        end
    endtask

    task automatic pwm_period(input logic [1:0] line, input int hi, input int lo);
        run(line, hi);
        run(2'b00, lo);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {13'd0, duty, period, speed, direction}, 32'd0);
        check({tag, "_valid_fault"}, {30'd0, valid, fault}, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        rst    = 1'b1;
        pwm_in = 2'b00;

        // Reset: cycles 1..3
        run(2'b00, 3);
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // 8/10 forward, periods start at 4,14,24,34
        for (int k = 0; k < 4; k++) push(8'd8, 8'd10, 2'd1, 1'b1, 15 + 10 * k);
        for (int k = 0; k < 4; k++) pwm_period(2'b01, 8, 2);

        // 9/10 reverse, periods start at 44,54,64,74
        for (int k = 0; k < 3; k++) push(8'd9, 8'd10, 2'd2, 1'b0, 55 + 10 * k);
        push(8'd9, 8'd10, 2'd2, 1'b0, 85);
        for (int k = 0; k < 4; k++) pwm_period(2'b10, 9, 1);

        // Forward held high from 84: timeout publishes every 20 cycles
        for (int k = 0; k < 3; k++) push(8'd10, 8'd0, 2'd3, 1'b1, 105 + 20 * k);
        run(2'b01, 63);

        // Short burst then held low: last edge is the fall at 157
        push(8'd0, 8'd0, 2'd0, 1'b1, 178);
        run(2'b00, 5);
        run(2'b01, 5);
        run(2'b00, 24);

        // 3 high then 20 low: the closing rise lands on the timeout cycle
        push(8'd3, 8'd23, 2'd1, 1'b1, 205);
        run(2'b01, 3);
        run(2'b00, 20);

        // Shoot-through for 3 cycles inside a high phase (cycles 206..208)
        push(8'd8, 8'd10, 2'd1, 1'b1, 225);
        push(8'd8, 8'd10, 2'd1, 1'b1, 235);
        push(8'd8, 8'd10, 2'd1, 1'b1, 245);
        step(2'b01);
        step(2'b01);
        check("fault_before", {31'd0, fault}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(2'b11);
            check("fault_active", {31'd0, fault}, 32'd1);
        end
        step(2'b01);
        check("fault_cleared", {31'd0, fault}, 32'd0);
        run(2'b01, 2);
        run(2'b00, 2);
        for (int k = 0; k < 3; k++) pwm_period(2'b01, 8, 2);

        // Reset pulsed in a high phase at cycle 247
        run(2'b01, 3);
        rst = 1'b1;
        step(2'b01);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        push(8'd8, 8'd10, 2'd1, 1'b1, 265);
        run(2'b01, 4);
        run(2'b00, 2);
        pwm_period(2'b01, 8, 2);
        run(2'b01, 5);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
